// File: rtl/mdc_tcdm_periph_bridge_pkg.sv
// Shared constants and the TCDM request layout used by the TCDM/peripheral bridge.
// Each FIFO entry packs {add, wen, be, data} with the address in the top bits.
package mdc_bridge_package;

  localparam int unsigned BRIDGE_MP         = 3;
  localparam int unsigned BRIDGE_ID         = 10;
  localparam int unsigned BRIDGE_ADDR_W     = 32;
  localparam int unsigned BRIDGE_DATA_W     = 32;
  localparam int unsigned BRIDGE_FIFO_DEPTH = 2;
  localparam int unsigned BRIDGE_MAX_OUT    = 4;
  localparam int unsigned BRIDGE_BE_W       = BRIDGE_DATA_W / 8;

  typedef struct packed {
    logic [BRIDGE_ADDR_W-1:0] add;
    logic                     wen;
    logic [BRIDGE_BE_W-1:0]   be;
    logic [BRIDGE_DATA_W-1:0] data;
  } tcdm_req_t;

  // Width of one packed request for arbitrary address/data widths.
  function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
    return aw + 1 + dw / 8 + dw;
  endfunction

endpackage

// File: rtl/mdc_tcdm_periph_bridge_req_fifo.sv
// Per-channel request FIFO with synchronous flush.
// No fall-through: a pushed entry reaches the head one cycle later; the head reads 0 when empty.
module mdc_tcdm_req_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full & ~i_clear;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/mdc_tcdm_periph_bridge.sv
// Bridge between flat cluster TCDM/peripheral ports and the accelerator side:
// buffered TCDM requests with outstanding tracking, plus a registered peripheral response slice.
module mdc_tcdm_periph_bridge
  import mdc_bridge_package::*;
#(
  parameter int unsigned MP         = BRIDGE_MP,
  parameter int unsigned ID         = BRIDGE_ID,
  parameter int unsigned ADDR_W     = BRIDGE_ADDR_W,
  parameter int unsigned DATA_W     = BRIDGE_DATA_W,
  parameter int unsigned FIFO_DEPTH = BRIDGE_FIFO_DEPTH,
  parameter int unsigned MAX_OUT    = BRIDGE_MAX_OUT
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic [MP-1:0]                  acc_req_i,
  output logic [MP-1:0]                  acc_gnt_o,
  input  logic [MP-1:0][ADDR_W-1:0]      acc_add_i,
  input  logic [MP-1:0]                  acc_wen_i,
  input  logic [MP-1:0][DATA_W/8-1:0]    acc_be_i,
  input  logic [MP-1:0][DATA_W-1:0]      acc_data_i,
  output logic [MP-1:0][DATA_W-1:0]      acc_r_data_o,
  output logic [MP-1:0]                  acc_r_valid_o,
  output logic [MP-1:0]                  tcdm_req,
  input  logic [MP-1:0]                  tcdm_gnt,
  output logic [MP-1:0][ADDR_W-1:0]      tcdm_add,
  output logic [MP-1:0]                  tcdm_wen,
  output logic [MP-1:0][DATA_W/8-1:0]    tcdm_be,
  output logic [MP-1:0][DATA_W-1:0]      tcdm_data,
  input  logic [MP-1:0][DATA_W-1:0]      tcdm_r_data,
  input  logic [MP-1:0]                  tcdm_r_valid,
  input  logic                           periph_req,
  output logic                           periph_gnt,
  input  logic [ADDR_W-1:0]              periph_add,
  input  logic                           periph_wen,
  input  logic [DATA_W/8-1:0]            periph_be,
  input  logic [DATA_W-1:0]              periph_data,
  input  logic [ID-1:0]                  periph_id,
  output logic [DATA_W-1:0]              periph_r_data,
  output logic                           periph_r_valid,
  output logic [ID-1:0]                  periph_r_id,
  output logic                           reg_req_o,
  input  logic                           reg_gnt_i,
  output logic [ADDR_W-1:0]              reg_add_o,
  output logic                           reg_wen_o,
  output logic [DATA_W/8-1:0]            reg_be_o,
  output logic [DATA_W-1:0]              reg_data_o,
  input  logic [DATA_W-1:0]              reg_r_data_i,
  output logic                           busy_o,
  output logic [MP-1:0]                  err_o
);

  localparam int unsigned REQ_W = req_width(ADDR_W, DATA_W);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [MP-1:0] w_full;
  logic [MP-1:0] w_empty;
  logic [MP-1:0] w_push;
  logic [MP-1:0] w_issue;
  logic [MP-1:0] w_cnt_nz;

  for (genvar gi = 0; gi < MP; gi++) begin : g_ch
    logic [REQ_W-1:0] w_head;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Grant is masked during reset so nothing is accepted while the bridge is held.
    assign acc_gnt_o[gi] = rst_ni & ~w_full[gi];
    assign w_push[gi]    = acc_req_i[gi] & acc_gnt_o[gi];

    mdc_tcdm_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
    ) i_req_fifo (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clear (clear_i),
      .i_push  (w_push[gi]),
      .i_data  ({acc_add_i[gi], acc_wen_i[gi], acc_be_i[gi], acc_data_i[gi]}),
      .i_pop   (w_issue[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head)
    );

    assign {tcdm_add[gi], tcdm_wen[gi], tcdm_be[gi], tcdm_data[gi]} = w_head;
    assign tcdm_req[gi] = ~w_empty[gi] & (r_cnt < CNT_MAX);
    assign w_issue[gi]  = tcdm_req[gi] & tcdm_gnt[gi];

    // A response with nothing outstanding is flagged rather than underflowing the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_issue[gi] && !tcdm_r_valid[gi]) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (!w_issue[gi] && tcdm_r_valid[gi] && (r_cnt != '0)) begin
          r_cnt <= r_cnt - 1'b1;
        end
        if (clear_i) begin
          r_err <= 1'b0;
        end else if (tcdm_r_valid[gi] && (r_cnt == '0)) begin
          r_err <= 1'b1;
        end
      end
    end

    assign w_cnt_nz[gi] = |r_cnt;
    assign err_o[gi]    = r_err;
  end

  assign acc_r_data_o  = tcdm_r_data;
  assign acc_r_valid_o = tcdm_r_valid;
  assign busy_o        = (|(~w_empty)) | (|w_cnt_nz);

  logic              w_p_fire;
  logic              r_p_valid;
  logic [ID-1:0]     r_p_id;
  logic [DATA_W-1:0] r_p_data;

  assign reg_req_o  = periph_req & rst_ni;
  assign reg_add_o  = periph_add;
  assign reg_wen_o  = periph_wen;
  assign reg_be_o   = periph_be;
  assign reg_data_o = periph_data;
  assign periph_gnt = reg_gnt_i & rst_ni;
  assign w_p_fire   = periph_req & periph_gnt;

  // Read data is captured in the request cycle; write responses carry zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_p_valid <= 1'b0;
      r_p_id    <= '0;
      r_p_data  <= '0;
    end else begin
      r_p_valid <= w_p_fire;
      r_p_id    <= w_p_fire ? periph_id : '0;
      r_p_data  <= (w_p_fire && periph_wen) ? reg_r_data_i : '0;
    end
  end

  assign periph_r_valid = r_p_valid;
  assign periph_r_id    = r_p_id;
  assign periph_r_data  = r_p_data;

endmodule

// File: tb/tb_mdc_tcdm_periph_bridge.sv
// Randomised bench for mdc_tcdm_periph_bridge: queue-based channel model, a TCDM memory
// responder with random in-order latency, and a one-cycle peripheral response model.
module tb_mdc_tcdm_periph_bridge;

  localparam int MP = 3, IDW = 10, AW = 32, DW = 32, BW = 4, DEPTH = 2, MAXO = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0;
  logic [MP-1:0]         acc_req_i, acc_gnt_o, acc_wen_i, acc_r_valid_o;
  logic [MP-1:0]         tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, err_o;
  logic [MP-1:0][AW-1:0] acc_add_i, tcdm_add;
  logic [MP-1:0][BW-1:0] acc_be_i, tcdm_be;
  logic [MP-1:0][DW-1:0] acc_data_i, acc_r_data_o, tcdm_data, tcdm_r_data;
  logic           periph_req, periph_gnt, periph_wen, periph_r_valid;
  logic [AW-1:0]  periph_add;
  logic [BW-1:0]  periph_be;
  logic [DW-1:0]  periph_data, periph_r_data;
  logic [IDW-1:0] periph_id, periph_r_id;
  logic           reg_req_o, reg_gnt_i, reg_wen_o;
  logic [AW-1:0]  reg_add_o;
  logic [BW-1:0]  reg_be_o;
  logic [DW-1:0]  reg_data_o, reg_r_data_i;
  logic           busy_o;

  mdc_tcdm_periph_bridge #(
    .MP(MP), .ID(IDW), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .acc_req_i(acc_req_i), .acc_gnt_o(acc_gnt_o), .acc_add_i(acc_add_i), .acc_wen_i(acc_wen_i),
    .acc_be_i(acc_be_i), .acc_data_i(acc_data_i), .acc_r_data_o(acc_r_data_o),
    .acc_r_valid_o(acc_r_valid_o),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_valid(tcdm_r_valid),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add),
    .periph_wen(periph_wen), .periph_be(periph_be), .periph_data(periph_data),
    .periph_id(periph_id), .periph_r_data(periph_r_data), .periph_r_valid(periph_r_valid),
    .periph_r_id(periph_r_id),
    .reg_req_o(reg_req_o), .reg_gnt_i(reg_gnt_i), .reg_add_o(reg_add_o), .reg_wen_o(reg_wen_o),
    .reg_be_o(reg_be_o), .reg_data_o(reg_data_o), .reg_r_data_i(reg_r_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq [MP][$];
  int   pend [MP][$];
  int   mcnt [MP];
  bit   merr [MP];
  int   gcnt [MP];
  bit   pv;
  logic [IDW-1:0] pid;
  logic [DW-1:0]  pdata;
  int   cyc_n;
  bit   hold_rv, rd_fix_en;
  logic [DW-1:0] rd_fix;
  int   dly_lo = 1, dly_hi = 1;
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h (cycle %0d)", nm, c, act, exp, cyc_n);
    end
  endtask

  // Memory responder: answers granted requests in order after their due cycle.
  task automatic drive_mem();
    for (int c = 0; c < MP; c++) begin
      tcdm_r_valid[c] = 1'b0;
      tcdm_r_data[c]  = rd_fix_en ? rd_fix : $urandom;
      if (!hold_rv && pend[c].size() > 0 && pend[c][0] <= cyc_n) begin
        tcdm_r_valid[c] = 1'b1;
        void'(pend[c].pop_front());
      end
    end
  endtask

  // Compare every output against the model, then advance the model by one clock.
  task automatic cyc();
    bit   ereq [MP];
    bit   any_busy;
    ent_t hd;
    #1;
    any_busy = 1'b0;
    for (int c = 0; c < MP; c++) begin
      ereq[c] = (mq[c].size() > 0) && (mcnt[c] < MAXO);
      hd = (mq[c].size() > 0) ? mq[c][0] : '0;
      chk("acc_gnt", c, acc_gnt_o[c], mq[c].size() < DEPTH);
      chk("tcdm_req", c, tcdm_req[c], ereq[c]);
      chk("tcdm_add", c, tcdm_add[c], hd.add);
      chk("tcdm_wen", c, tcdm_wen[c], hd.wen);
      chk("tcdm_be", c, tcdm_be[c], hd.be);
      chk("tcdm_data", c, tcdm_data[c], hd.data);
      chk("acc_r_valid", c, acc_r_valid_o[c], tcdm_r_valid[c]);
      chk("acc_r_data", c, acc_r_data_o[c], tcdm_r_data[c]);
      chk("err", c, err_o[c], merr[c]);
      if (mq[c].size() > 0 || mcnt[c] != 0) any_busy = 1'b1;
    end
    chk("busy", -1, busy_o, any_busy);
    chk("periph_gnt", -1, periph_gnt, reg_gnt_i);
    chk("reg_req", -1, reg_req_o, periph_req);
    chk("reg_add", -1, reg_add_o, periph_add);
    chk("reg_wen", -1, reg_wen_o, periph_wen);
    chk("reg_be", -1, reg_be_o, periph_be);
    chk("reg_data", -1, reg_data_o, periph_data);
    chk("p_r_valid", -1, periph_r_valid, pv);
    chk("p_r_id", -1, periph_r_id, pid);
    chk("p_r_data", -1, periph_r_data, pdata);
    for (int c = 0; c < MP; c++) begin
      bit   push, pop, rv;
      int   due;
      ent_t e;
      push = acc_req_i[c] && (mq[c].size() < DEPTH);
      pop  = ereq[c] && tcdm_gnt[c];
      rv   = tcdm_r_valid[c];
      if (tcdm_req[c] && tcdm_gnt[c]) gcnt[c]++;
      if (pop) begin
        due = cyc_n + $urandom_range(dly_hi, dly_lo);
        if (pend[c].size() > 0 && due <= pend[c][$]) due = pend[c][$] + 1;
        pend[c].push_back(due);
      end
      if (clear_i) merr[c] = 1'b0;
      else if (rv && mcnt[c] == 0) merr[c] = 1'b1;
      if (pop && !rv) mcnt[c]++;
      else if (rv && !pop && mcnt[c] > 0) mcnt[c]--;
      if (clear_i) mq[c].delete();
      else begin
        if (pop) void'(mq[c].pop_front());
        if (push) begin
          e.add = acc_add_i[c]; e.wen = acc_wen_i[c]; e.be = acc_be_i[c]; e.data = acc_data_i[c];
          mq[c].push_back(e);
        end
      end
    end
    pv    = periph_req && reg_gnt_i;
    pid   = pv ? periph_id : '0;
    pdata = (pv && periph_wen) ? reg_r_data_i : '0;
    cyc_n++;
    @(negedge clk_i);
    drive_mem();
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < MP; c++) begin
      acc_add_i[c]  = $urandom;
      acc_data_i[c] = $urandom;
      acc_be_i[c]   = 4'($urandom);
      acc_wen_i[c]  = 1'($urandom);
    end
    acc_req_i    = 3'($urandom);
    tcdm_gnt     = 3'($urandom);
    clear_i      = ($urandom_range(0, 63) == 0);
    if ($urandom_range(0, 15) == 0) hold_rv = ~hold_rv;
    periph_req   = 1'($urandom);
    reg_gnt_i    = 1'($urandom);
    periph_wen   = 1'($urandom);
    periph_add   = $urandom;
    periph_be    = 4'($urandom);
    periph_data  = $urandom;
    periph_id    = 10'($urandom);
    reg_r_data_i = $urandom;
  endtask

  initial begin
    for (int c = 0; c < MP; c++) begin
      mcnt[c] = 0; merr[c] = 1'b0; gcnt[c] = 0;
    end
    pv = 1'b0; pid = '0; pdata = '0; cyc_n = 0; hold_rv = 1'b0; rd_fix_en = 1'b0; rd_fix = '0;
    acc_req_i = '1; acc_add_i = '0; acc_wen_i = '0; acc_be_i = '0; acc_data_i = '0;
    tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0;
    periph_req = 1'b1; reg_gnt_i = 1'b1; periph_add = '0; periph_wen = 1'b0; periph_be = '0;
    periph_data = '0; periph_id = '0; reg_r_data_i = '0;

    // Reset: everything quiet even with requests pending on the inputs.
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_acc_gnt", -1, acc_gnt_o, 0);
    chk("rst_tcdm_req", -1, tcdm_req, 0);
    chk("rst_busy", -1, busy_o, 0);
    chk("rst_err", -1, err_o, 0);
    chk("rst_p_valid", -1, periph_r_valid, 0);
    chk("rst_p_gnt", -1, periph_gnt, 0);
    chk("rst_reg_req", -1, reg_req_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; acc_req_i = '0; periph_req = 1'b0; reg_gnt_i = 1'b0;
    drive_mem();

    // Single read on ch0, one-cycle response.
    tcdm_gnt = '1; rd_fix_en = 1'b1; rd_fix = 32'hDEADBEEF;
    acc_req_i = 3'b001; acc_add_i[0] = 32'h100; acc_wen_i[0] = 1'b1;
    #1 chk("t1_no_fallthru", 0, tcdm_req[0], 0);
    cyc();
    acc_req_i = '0;
    #1 chk("t1_req", 0, tcdm_req[0], 1);
    chk("t1_add", 0, tcdm_add[0], 64'h100);
    cyc();
    #1 chk("t1_rvalid", 0, acc_r_valid_o[0], 1);
    chk("t1_rdata", 0, acc_r_data_o[0], 64'hDEADBEEF);
    chk("t1_busy", 0, busy_o, 1);
    cyc();
    #1 chk("t1_idle", 0, busy_o, 0);
    cyc();
    rd_fix_en = 1'b0;

    // FIFO full on ch1 with the TCDM stalled.
    tcdm_gnt = '0; acc_req_i = 3'b010;
    acc_add_i[1] = 32'hA1;
    #1 chk("t2_gnt1", 1, acc_gnt_o[1], 1);
    cyc();
    acc_add_i[1] = 32'hA2;
    #1 chk("t2_gnt2", 1, acc_gnt_o[1], 1);
    cyc();
    acc_add_i[1] = 32'hA3;
    #1 chk("t2_gnt3", 1, acc_gnt_o[1], 0);
    chk("t2_stall_add", 1, tcdm_add[1], 64'hA1);
    cyc();
    acc_req_i = '0;
    #1 chk("t2_stall_add2", 1, tcdm_add[1], 64'hA1);
    cyc();
    tcdm_gnt = '1;
    #1 chk("t2_first", 1, tcdm_add[1], 64'hA1);
    cyc();
    #1 chk("t2_second", 1, tcdm_add[1], 64'hA2);
    chk("t2_second_req", 1, tcdm_req[1], 1);
    cyc();
    repeat (6) cyc();

    // Outstanding limit on ch2.
    hold_rv = 1'b1; acc_req_i = 3'b100; gcnt[2] = 0;
    repeat (8) cyc();
    #1 chk("t3_grants", 2, gcnt[2], 4);
    chk("t3_req_off", 2, tcdm_req[2], 0);
    gcnt[2] = 0; hold_rv = 1'b0;
    cyc();
    hold_rv = 1'b1;
    repeat (6) cyc();
    chk("t3_one_more", 2, gcnt[2], 1);
    acc_req_i = '0; hold_rv = 1'b0;
    repeat (15) cyc();

    // Spurious response on ch1.
    tcdm_r_valid[1] = 1'b1;
    cyc();
    #1 chk("t4_err", 1, err_o[1], 1);
    chk("t4_cnt0", 1, busy_o, 0);
    cyc();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1 chk("t4_cleared", -1, err_o, 0);
    cyc();

    // Flush on ch2 with two queued and one in flight.
    hold_rv = 1'b1; tcdm_gnt = '0; acc_req_i = 3'b100;
    cyc();
    tcdm_gnt[2] = 1'b1;
    cyc();
    tcdm_gnt = '0;
    cyc();
    acc_req_i = '0; clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1 chk("t5_flushed", 2, tcdm_req[2], 0);
    chk("t5_busy", 2, busy_o, 1);
    cyc();
    cyc();
    #1 chk("t5_busy_hold", 2, busy_o, 1);
    hold_rv = 1'b0;
    cyc();
    #1 chk("t5_rvalid", 2, acc_r_valid_o[2], 1);
    chk("t5_busy_last", 2, busy_o, 1);
    cyc();
    #1 chk("t5_idle", 2, busy_o, 0);
    tcdm_gnt = '1;
    cyc();

    // Peripheral read then write, back to back.
    reg_gnt_i = 1'b1; periph_req = 1'b1; periph_wen = 1'b1; periph_id = 10'h15;
    reg_r_data_i = 32'h1234;
    cyc();
    periph_wen = 1'b0; periph_id = 10'h2A; reg_r_data_i = 32'h5555;
    #1 chk("t6_v1", -1, periph_r_valid, 1);
    chk("t6_d1", -1, periph_r_data, 64'h1234);
    chk("t6_id1", -1, periph_r_id, 64'h15);
    cyc();
    periph_req = 1'b0;
    #1 chk("t6_v2", -1, periph_r_valid, 1);
    chk("t6_d2", -1, periph_r_data, 0);
    chk("t6_id2", -1, periph_r_id, 64'h2A);
    cyc();
    #1 chk("t6_v3", -1, periph_r_valid, 0);
    cyc();

    // Random traffic.
    dly_lo = 1; dly_hi = 4;
    repeat (3000) begin
      rand_inputs();
      cyc();
    end

    // Drain and confirm the bridge goes idle.
    acc_req_i = '0; tcdm_gnt = '1; hold_rv = 1'b0; clear_i = 1'b0; periph_req = 1'b0;
    repeat (25) cyc();
    #1 chk("end_busy", -1, busy_o, 0);
    chk("end_err", -1, err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
